// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed byte image and writes it into memory word by word, then releases the CPU.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        MemWrite,
  output logic [31:0] DataAdr,
  output logic [31:0] WriteData,
  output logic        start,
  output logic        err,
  output logic [15:0] words_loaded
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;
  localparam logic [15:0] MAXW = 16'(MAX_WORDS);
  state_t state, next;
  logic [15:0] n;
  logic [15:0] hdr;
  logic [1:0] idx;
  logic [23:0] asm_w;
  logic acc;
  assign acc = in_valid & in_ready;
  assign hdr = {in_data, n[7:0]};
  always_ff @(posedge clk)
    if (!reset) state <= HDR0;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      HDR0:  next = acc ? HDR1 : HDR0;
      HDR1:  next = !acc ? HDR1 : hdr == 16'd0 ? DONE : hdr > MAXW ? ERR : DATA;
      DATA:  next = (acc && idx == 2'd3) ? WRITE : DATA;
      WRITE: next = (words_loaded + 16'd1 == n) ? DONE : DATA;
      default: next = state;
    endcase
  end
  always_comb begin
    in_ready = reset && (state == HDR0 || state == HDR1 || state == DATA);
    MemWrite = state == WRITE;
    start = state == DONE;
    err = state == ERR;
  end
  // address/data are captured with the 4th byte so they are stable through WRITE and held afterwards
  always_ff @(posedge clk)
    if (!reset) begin
      n <= '0;
      idx <= '0;
      asm_w <= '0;
      DataAdr <= '0;
      WriteData <= '0;
      words_loaded <= '0;
    end else begin
      if (acc && state == HDR0) n[7:0] <= in_data;
      if (acc && state == HDR1) begin
        n[15:8] <= in_data;
        idx <= '0;
      end
      if (acc && state == DATA) begin
        idx <= idx + 2'd1;
        if (idx == 2'd0) asm_w[7:0] <= in_data;
        if (idx == 2'd1) asm_w[15:8] <= in_data;
        if (idx == 2'd2) asm_w[23:16] <= in_data;
        if (idx == 2'd3) begin
          DataAdr <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
          WriteData <= {in_data, asm_w};
        end
      end
      if (state == WRITE) words_loaded <= words_loaded + 16'd1;
    end
endmodule
